de_pipe_reg: RTL and testbench



---
 rtl/de_pipe_reg.sv | 190 +++++++++++++++++++
 tb/tb_de_pipe_reg.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/de_pipe_reg.sv
// D-to-E pipeline register for the 5-stage MIPS core.
// Captures the D-stage instruction, PC, forwarded operands and immediate.
// Inserts bubbles on stall and freezes on hold.
// Precomputes the E-stage write address and result timing so downstream
// hazard/forwarding logic never has to re-decode the instruction.
module de_pipe_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             hold,
  input  logic [31:0]      instr_D,
  input  logic [31:0]      pc_D,
  input  logic [31:0]      rs_data_D,
  input  logic [31:0]      rt_data_D,
  input  logic [31:0]      ext_D,
  output logic [31:0]      instr_E,
  output logic [31:0]      pc_E,
  output logic [31:0]      pc8_E,
  output logic [31:0]      rs_data_E,
  output logic [31:0]      rt_data_E,
  output logic [31:0]      ext_E,
  output logic [4:0]       a3_E,
  output logic [1:0]       tnew_E,
  output logic             bubble_E,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_SLTIU  = 6'b001011;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_XORI   = 6'b001110;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_LB     = 6'b100000;
  localparam logic [5:0] OP_LW     = 6'b100011;

  localparam logic [5:0] FN_SLL    = 6'b000000;
  localparam logic [5:0] FN_SRL    = 6'b000010;
  localparam logic [5:0] FN_SRA    = 6'b000011;
  localparam logic [5:0] FN_SLLV   = 6'b000100;
  localparam logic [5:0] FN_SRLV   = 6'b000110;
  localparam logic [5:0] FN_JALR   = 6'b001001;
  localparam logic [5:0] FN_MOVZ   = 6'b001010;
  localparam logic [5:0] FN_ADD    = 6'b100000;
  localparam logic [5:0] FN_ADDU   = 6'b100001;
  localparam logic [5:0] FN_SUB    = 6'b100010;
  localparam logic [5:0] FN_SUBU   = 6'b100011;
  localparam logic [5:0] FN_AND    = 6'b100100;
  localparam logic [5:0] FN_OR     = 6'b100101;
  localparam logic [5:0] FN_XOR    = 6'b100110;
  localparam logic [5:0] FN_NOR    = 6'b100111;
  localparam logic [5:0] FN_SLT    = 6'b101010;

  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;
  localparam logic [4:0] REG_RA    = 5'd31;

  logic [5:0]       w_op;
  logic [5:0]       w_funct;
  logic [4:0]       w_rt;
  logic [4:0]       w_rd;
  logic [4:0]       w_a3;
  logic [1:0]       w_tnew;

  logic [31:0]      r_instr;
  logic [31:0]      r_pc;
  logic [31:0]      r_rs;
  logic [31:0]      r_rt;
  logic [31:0]      r_ext;
  logic [4:0]       r_a3;
  logic [1:0]       r_tnew;
  logic             r_bubble;
  logic [CNT_W-1:0] r_cnt;

  assign w_op    = instr_D[31:26];
  assign w_funct = instr_D[5:0];
  assign w_rt    = instr_D[20:16];
  assign w_rd    = instr_D[15:11];

  // Decode destination register and result latency of the D instruction; no destination means nothing to wait for
  always_comb begin
    w_a3   = 5'd0;
    w_tnew = 2'd0;
    case (w_op)
      OP_RTYPE: begin
        case (w_funct)
          FN_ADDU, FN_ADD, FN_SUBU, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_NOR,
          FN_SLT, FN_SLL, FN_SLLV, FN_SRL, FN_SRLV, FN_SRA: begin
            w_a3   = w_rd;
            w_tnew = 2'd1;
          end
          FN_JALR: begin
            w_a3   = w_rd;
            w_tnew = 2'd0;
          end
          FN_MOVZ: begin
            w_a3   = (rt_data_D == 32'd0) ? w_rd : 5'd0;
            w_tnew = 2'd1;
          end
          default: begin
            w_a3   = 5'd0;
            w_tnew = 2'd0;
          end
        endcase
      end
      OP_ADDI, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        w_a3   = w_rt;
        w_tnew = 2'd1;
      end
      OP_LW, OP_LB: begin
        w_a3   = w_rt;
        w_tnew = 2'd2;
      end
      OP_JAL: begin
        w_a3   = REG_RA;
        w_tnew = 2'd0;
      end
      OP_REGIMM: begin
        if ((w_rt == RT_BGEZAL) || (w_rt == RT_BLTZAL)) begin
          w_a3 = REG_RA;
        end
        w_tnew = 2'd0;
      end
      default: begin
        w_a3   = 5'd0;
        w_tnew = 2'd0;
      end
    endcase
    if (w_a3 == 5'd0) begin
      w_tnew = 2'd0;
    end
  end

  // Pipeline register: reset beats hold, hold beats stall, stall inserts a counted bubble keeping the D PC
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr  <= 32'd0;
      r_pc     <= RESET_PC;
      r_rs     <= 32'd0;
      r_rt     <= 32'd0;
      r_ext    <= 32'd0;
      r_a3     <= 5'd0;
      r_tnew   <= 2'd0;
      r_bubble <= 1'b1;
      r_cnt    <= '0;
    end else if (hold) begin
      r_instr  <= r_instr;
    end else if (stall) begin
      r_instr  <= 32'd0;
      r_pc     <= pc_D;
      r_rs     <= 32'd0;
      r_rt     <= 32'd0;
      r_ext    <= 32'd0;
      r_a3     <= 5'd0;
      r_tnew   <= 2'd0;
      r_bubble <= 1'b1;
      if (r_cnt != {CNT_W{1'b1}}) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else begin
      r_instr  <= instr_D;
      r_pc     <= pc_D;
      r_rs     <= rs_data_D;
      r_rt     <= rt_data_D;
      r_ext    <= ext_D;
      r_a3     <= w_a3;
      r_tnew   <= w_tnew;
      r_bubble <= 1'b0;
    end
  end

  assign instr_E    = r_instr;
  assign pc_E       = r_pc;
  assign pc8_E      = r_pc + 32'd8;
  assign rs_data_E  = r_rs;
  assign rt_data_E  = r_rt;
  assign ext_E      = r_ext;
  assign a3_E       = r_a3;
  assign tnew_E     = r_tnew;
  assign bubble_E   = r_bubble;
  assign bubble_cnt = r_cnt;

endmodule

// File: tb/tb_de_pipe_reg.sv
// Self-checking bench for de_pipe_reg: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
module tb_de_pipe_reg;

  localparam int CNT_W = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic             clk = 1'b0;
  logic             reset, stall, hold;
  logic [31:0]      instr_D, pc_D, rs_data_D, rt_data_D, ext_D;
  logic [31:0]      instr_E, pc_E, pc8_E, rs_data_E, rt_data_E, ext_E;
  logic [4:0]       a3_E;
  logic [1:0]       tnew_E;
  logic             bubble_E;
  logic [CNT_W-1:0] bubble_cnt;

  int checkCount = 0;
  int errorCount = 0;

  logic [31:0] expInstr, expPc, expRs, expRt, expExt;
  logic [4:0]  expA3;
  logic [1:0]  expTnew;
  logic        expBubble;
  int          expCnt;

  logic [5:0] rAluFuncts [15] = '{6'h21, 6'h20, 6'h23, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27,
                                 6'h2A, 6'h00, 6'h04, 6'h02, 6'h06, 6'h03, 6'h09};
  logic [5:0] iAluOps [7]     = '{6'h08, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
  logic [5:0] noWriteOps [6]  = '{6'h2B, 6'h28, 6'h04, 6'h05, 6'h02, 6'h3F};
  logic [4:0] regimmRts [4]   = '{5'b10000, 5'b10001, 5'b00000, 5'b00001};

  always #5 clk = ~clk;

  de_pipe_reg #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .stall(stall), .hold(hold),
    .instr_D(instr_D), .pc_D(pc_D), .rs_data_D(rs_data_D), .rt_data_D(rt_data_D), .ext_D(ext_D),
    .instr_E(instr_E), .pc_E(pc_E), .pc8_E(pc8_E), .rs_data_E(rs_data_E), .rt_data_E(rt_data_E),
    .ext_E(ext_E), .a3_E(a3_E), .tnew_E(tnew_E), .bubble_E(bubble_E), .bubble_cnt(bubble_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Architectural meaning of an instruction: which register it writes and when the value exists
  function automatic void modelDecode(input logic [31:0] ins, input logic [31:0] rtVal,
                                      output logic [4:0] dest, output logic [1:0] ready);
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    dest  = 5'd0;
    ready = 2'd0;
    if (op == 6'h00 && fn == 6'h09) begin
      dest = ins[15:11];
      ready = 2'd0;
    end else if (op == 6'h00 && fn == 6'h0A) begin
      dest = (rtVal == 0) ? ins[15:11] : 5'd0;
      ready = 2'd1;
    end else if (op == 6'h00 && fn inside {6'h21, 6'h20, 6'h23, 6'h22, 6'h24, 6'h25, 6'h26,
                                           6'h27, 6'h2A, 6'h00, 6'h04, 6'h02, 6'h06, 6'h03}) begin
      dest = ins[15:11];
      ready = 2'd1;
    end else if (op inside {6'h08, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F}) begin
      dest = ins[20:16];
      ready = 2'd1;
    end else if (op == 6'h23 || op == 6'h20) begin
      dest = ins[20:16];
      ready = 2'd2;
    end else if (op == 6'h03) begin
      dest = 5'd31;
    end else if (op == 6'h01 && (ins[20:16] == 5'b10000 || ins[20:16] == 5'b10001)) begin
      dest = 5'd31;
    end
    if (dest == 5'd0) ready = 2'd0;
  endfunction

  // Advance the model by one clock edge using the currently driven inputs
  task automatic modelStep();
    logic [4:0] d;
    logic [1:0] r;
    if (reset) begin
      expInstr = 0; expPc = RESET_PC; expRs = 0; expRt = 0; expExt = 0;
      expA3 = 0; expTnew = 0; expBubble = 1'b1; expCnt = 0;
    end else if (hold) begin
      expCnt = expCnt;
    end else if (stall) begin
      expInstr = 0; expPc = pc_D; expRs = 0; expRt = 0; expExt = 0;
      expA3 = 0; expTnew = 0; expBubble = 1'b1;
      if (expCnt < (1 << CNT_W) - 1) expCnt = expCnt + 1;
    end else begin
      modelDecode(instr_D, rt_data_D, d, r);
      expInstr = instr_D; expPc = pc_D; expRs = rs_data_D; expRt = rt_data_D; expExt = ext_D;
      expA3 = d; expTnew = r; expBubble = 1'b0;
    end
  endtask

  task automatic checkAll();
    checkOutput("instr_E", instr_E, expInstr);
    checkOutput("pc_E", pc_E, expPc);
    checkOutput("pc8_E", pc8_E, expPc + 32'd8);
    checkOutput("rs_data_E", rs_data_E, expRs);
    checkOutput("rt_data_E", rt_data_E, expRt);
    checkOutput("ext_E", ext_E, expExt);
    checkOutput("a3_E", 32'(a3_E), 32'(expA3));
    checkOutput("tnew_E", 32'(tnew_E), 32'(expTnew));
    checkOutput("bubble_E", 32'(bubble_E), 32'(expBubble));
    checkOutput("bubble_cnt", 32'(bubble_cnt), 32'(expCnt));
  endtask

  task automatic applyStimulus(input logic rst, input logic st, input logic hd,
                               input logic [31:0] ins, input logic [31:0] pc,
                               input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] ex);
    reset = rst; stall = st; hold = hd;
    instr_D = ins; pc_D = pc; rs_data_D = rs; rt_data_D = rt; ext_D = ex;
    modelStep();
    @(posedge clk);
    #1;
    checkAll();
  endtask

  function automatic logic [31:0] randomInstr();
    logic [31:0] ins;
    int kind;
    ins = $urandom;
    kind = $urandom_range(0, 9);
    case (kind)
      0, 1: ins = {6'h00, ins[25:6], rAluFuncts[$urandom_range(0, 14)]};
      2:    ins = {6'h00, ins[25:6], 6'h0A};
      3:    ins = {iAluOps[$urandom_range(0, 6)], ins[25:0]};
      4:    ins = {($urandom_range(0, 1) == 0) ? 6'h23 : 6'h20, ins[25:0]};
      5:    ins = {noWriteOps[$urandom_range(0, 5)], ins[25:0]};
      6:    ins = {6'h03, ins[25:0]};
      7:    ins = {6'h01, ins[25:21], regimmRts[$urandom_range(0, 3)], ins[15:0]};
      8:    ins = {6'h00, ins[25:0]};
      default: ins = ins;
    endcase
    return ins;
  endfunction

  initial begin
    logic [31:0] rtv;
    expCnt = 0;

    // Reset for two cycles
    applyStimulus(1, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    applyStimulus(1, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    checkOutput("rst_pc", pc_E, 32'h0000_3000);
    checkOutput("rst_pc8", pc8_E, 32'h0000_3008);
    checkOutput("rst_bubble", 32'(bubble_E), 32'd1);
    checkOutput("rst_cnt", 32'(bubble_cnt), 32'd0);

    // addu $3,$1,$2
    applyStimulus(0, 0, 0, 32'h0022_1821, 32'h0000_3004, 32'h11, 32'h22, 32'h1821);
    checkOutput("addu_a3", 32'(a3_E), 32'd3);
    checkOutput("addu_tnew", 32'(tnew_E), 32'd1);
    checkOutput("addu_pc8", pc8_E, 32'h0000_300C);

    // lw then two stall cycles
    applyStimulus(0, 0, 0, 32'h8C25_0004, 32'h0000_3008, 32'h100, 32'h5, 32'h4);
    checkOutput("lw_a3", 32'(a3_E), 32'd5);
    checkOutput("lw_tnew", 32'(tnew_E), 32'd2);
    applyStimulus(0, 1, 0, 32'h0000_0000, 32'h0000_300C, 32'h1, 32'h2, 32'h3);
    applyStimulus(0, 1, 0, 32'h0000_0000, 32'h0000_300C, 32'h1, 32'h2, 32'h3);
    checkOutput("stall_instr", instr_E, 32'h0);
    checkOutput("stall_cnt", 32'(bubble_cnt), 32'd2);

    // movz with zero and non-zero rt
    applyStimulus(0, 0, 0, 32'h0022_200A, 32'h0000_3010, 32'h9, 32'h0, 32'h0);
    checkOutput("movz0_a3", 32'(a3_E), 32'd4);
    applyStimulus(0, 0, 0, 32'h0022_200A, 32'h0000_3010, 32'h9, 32'h7, 32'h0);
    checkOutput("movz7_a3", 32'(a3_E), 32'd0);
    checkOutput("movz7_tnew", 32'(tnew_E), 32'd0);

    // Linking instructions and PC wrap
    applyStimulus(0, 0, 0, 32'h0431_0003, 32'h0000_3014, 32'h1, 32'h0, 32'h3);
    checkOutput("bgezal_a3", 32'(a3_E), 32'd31);
    applyStimulus(0, 0, 0, 32'h0C00_0C00, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0);
    checkOutput("jal_a3", 32'(a3_E), 32'd31);
    checkOutput("jal_pc8_wrap", pc8_E, 32'h0000_0004);

    // Hold and stall together freeze everything, then reset overrides hold
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 1, $urandom, $urandom, $urandom, $urandom, $urandom);
    end
    checkOutput("hold_instr", instr_E, 32'h0C00_0C00);
    checkOutput("hold_cnt", 32'(bubble_cnt), 32'd2);
    applyStimulus(1, 0, 1, $urandom, $urandom, $urandom, $urandom, $urandom);
    checkOutput("rst_hold_pc", pc_E, 32'h0000_3000);

    // Counter saturation
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 1, 0, $urandom, $urandom, $urandom, $urandom, $urandom);
    end
    checkOutput("cnt_sat", 32'(bubble_cnt), 32'd15);
    applyStimulus(1, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rtv = ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom;
      applyStimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 9) == 0), randomInstr(), $urandom,
                    $urandom, rtv, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
